// File: rtl/prompt_progress_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : prompt_progress_tracker_if
// Brief    : Keystroke/control inputs and progress/stat outputs of the tracker
// Revision : 1.0 - initial release
// ============================================================================
interface prompt_progress_tracker_if #(
  parameter int MAX_LEN = 64,
  parameter int ERR_W   = 8,
  parameter int TIME_W  = 12
);
  localparam int IDX_W = $clog2(MAX_LEN + 1);

  logic              start;
  logic [IDX_W-1:0]  prompt_len;
  logic              correct;
  logic              wrong;
  logic              tick;
  logic [IDX_W-1:0]  letter_idx;
  logic [ERR_W-1:0]  error_cnt;
  logic [IDX_W-1:0]  streak;
  logic [IDX_W-1:0]  best_streak;
  logic [TIME_W-1:0] elapsed;
  logic              active;
  logic              done;
  logic              done_pulse;

  modport master (
    output start, prompt_len, correct, wrong, tick,
    input  letter_idx, error_cnt, streak, best_streak, elapsed, active, done, done_pulse
  );

  modport slave (
    input  start, prompt_len, correct, wrong, tick,
    output letter_idx, error_cnt, streak, best_streak, elapsed, active, done, done_pulse
  );
endinterface
`default_nettype wire

// File: rtl/prompt_progress_tracker.sv
`default_nettype none
// ============================================================================
// Module   : prompt_progress_tracker
// Brief    : Tracks cursor, errors, streaks and elapsed time for a typing prompt
// Revision : 1.0 - initial release
// ============================================================================
module prompt_progress_tracker #(
  parameter int MAX_LEN = 64,
  parameter int ERR_W   = 8,
  parameter int TIME_W  = 12
) (
  input  wire logic                clk,
  input  wire logic                reset,
  prompt_progress_tracker_if.slave bus_if
);
  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam logic [IDX_W-1:0] C_LEN_MAX = IDX_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TYPING = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q,      state_d;
  logic [IDX_W-1:0]  len_q,        len_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [ERR_W-1:0]  err_q,        err_d;
  logic [IDX_W-1:0]  streak_q,     streak_d;
  logic [IDX_W-1:0]  best_q,       best_d;
  logic [TIME_W-1:0] elapsed_q,    elapsed_d;
  logic              done_pulse_q, done_pulse_d;

  logic [IDX_W-1:0]  w_len_clamped;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [IDX_W-1:0]  w_streak_inc;

  assign w_len_clamped = (bus_if.prompt_len > C_LEN_MAX) ? C_LEN_MAX : bus_if.prompt_len;
  assign w_idx_inc     = idx_q + IDX_W'(1);
  assign w_streak_inc  = streak_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      err_q        <= '0;
      streak_q     <= '0;
      best_q       <= '0;
      elapsed_q    <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      streak_q     <= streak_d;
      best_q       <= best_d;
      elapsed_q    <= elapsed_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    err_d        = err_q;
    streak_d     = streak_q;
    best_d       = best_q;
    elapsed_d    = elapsed_q;
    done_pulse_d = 1'b0;

    // start dominates every other input in any state
    if (bus_if.start) begin
      len_d     = w_len_clamped;
      idx_d     = '0;
      err_d     = '0;
      streak_d  = '0;
      best_d    = '0;
      elapsed_d = '0;
      if (w_len_clamped == '0) begin
        state_d      = S_DONE;
        done_pulse_d = 1'b1;
      end else begin
        state_d = S_TYPING;
      end
    end else if (state_q == S_TYPING) begin
      if (bus_if.correct) begin
        idx_d    = w_idx_inc;
        streak_d = w_streak_inc;
        if (w_streak_inc > best_q) begin
          best_d = w_streak_inc;
        end
        if (w_idx_inc == len_q) begin
          state_d      = S_DONE;
          done_pulse_d = 1'b1;
        end
      end else if (bus_if.wrong) begin
        if (err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
        streak_d = '0;
      end
      if (bus_if.tick && (elapsed_q != '1)) begin
        elapsed_d = elapsed_q + TIME_W'(1);
      end
    end
  end

  assign bus_if.letter_idx  = idx_q;
  assign bus_if.error_cnt   = err_q;
  assign bus_if.streak      = streak_q;
  assign bus_if.best_streak = best_q;
  assign bus_if.elapsed     = elapsed_q;
  assign bus_if.active      = (state_q == S_TYPING);
  assign bus_if.done        = (state_q == S_DONE);
  assign bus_if.done_pulse  = done_pulse_q;
endmodule
`default_nettype wire
